// File: rtl/vout_pwm_ramp_if.sv
// Bus between the host-side duty register and the PWM output stage.
// The host drives enable/dty; the output stage returns pin-level status.
interface vout_pwm_ramp_if #(
    parameter int WIDTH = 32
);
    logic                    enable;
    logic signed [WIDTH-1:0] dty;
    logic                    dir;
    logic                    pwm;
    logic                    sync;
    logic                    sat;

    modport master (
        output enable, dty,
        input  dir, pwm, sync, sat
    );

    modport slave (
        input  enable, dty,
        output dir, pwm, sync, sat
    );
endinterface

// File: rtl/vout_pwm_ramp.sv
// Sign/magnitude PWM output with saturation, per-period slew limiting and
// reversal dead time. Duty is sampled only at the period boundary.
module vout_pwm_ramp #(
    parameter int WIDTH     = 32,
    parameter int PERIOD    = 255,
    parameter int CENTER    = 0,
    parameter int RAMP_STEP = 0,
    parameter int DEADTIME  = 0
) (
    input  logic           clk,
    input  logic           reset,
    vout_pwm_ramp_if.slave bus
);

    // state    | meaning
    // ST_START | first clock after reset; the next clock is a boundary
    // ST_UP    | counter rising (the only phase in edge mode)
    // ST_DOWN  | counter falling (center mode only)
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]        PER_W   = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0]        PER_M1  = WIDTH'(PERIOD - 1);
    localparam logic signed [WIDTH:0]   PER_X   = (WIDTH+1)'(PERIOD);
    localparam logic signed [WIDTH:0]   STEP_X  = (WIDTH+1)'(RAMP_STEP);
    localparam logic [WIDTH-1:0]        DT_LOAD = WIDTH'((DEADTIME > 0) ? DEADTIME - 1 : 0);

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        cnt, cnt_nxt;
    logic [WIDTH-1:0]        dt_cnt, dt_nxt;
    logic signed [WIDTH-1:0] applied, applied_nxt;
    logic                    dir_q, dir_nxt;
    logic                    pwm_q, pwm_nxt;
    logic                    sync_q, sync_nxt;
    logic                    sat_q, sat_nxt;

    logic                    boundary;
    logic                    force_low;
    logic                    sat_smp;
    logic                    hit;
    logic signed [WIDTH:0]   dty_x, target_x, applied_x, diff_x, slewed_x;
    logic [WIDTH-1:0]        mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_START;
            cnt     <= '0;
            dt_cnt  <= '0;
            applied <= '0;
            dir_q   <= 1'b0;
            pwm_q   <= 1'b0;
            sync_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dt_cnt  <= dt_nxt;
            applied <= applied_nxt;
            dir_q   <= dir_nxt;
            pwm_q   <= pwm_nxt;
            sync_q  <= sync_nxt;
            sat_q   <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        boundary    = 1'b0;
        applied_nxt = applied;
        dir_nxt     = dir_q;
        sat_nxt     = sat_q;
        dt_nxt      = dt_cnt;
        force_low   = 1'b0;
        sat_smp     = 1'b0;
        hit         = 1'b0;

        case (state)
            ST_START: begin
                state_nxt = ST_UP;
                cnt_nxt   = '0;
                boundary  = 1'b1;
            end
            ST_UP: begin
                if (cnt == PER_M1) begin
                    if (CENTER != 0) begin
                        state_nxt = ST_DOWN;
                    end else begin
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end
            ST_DOWN: begin
                if (cnt == '0) begin
                    state_nxt = ST_UP;
                    boundary  = 1'b1;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_START;
                cnt_nxt   = '0;
            end
        endcase

        // One extra bit keeps -2^(WIDTH-1) and target-applied from overflowing.
        dty_x    = {bus.dty[WIDTH-1], bus.dty};
        target_x = dty_x;
        if (dty_x > PER_X) begin
            target_x = PER_X;
            sat_smp  = 1'b1;
        end else if (dty_x < -PER_X) begin
            target_x = -PER_X;
            sat_smp  = 1'b1;
        end

        applied_x = {applied[WIDTH-1], applied};
        diff_x    = target_x - applied_x;
        if (RAMP_STEP == 0)
            slewed_x = target_x;
        else if (diff_x > STEP_X)
            slewed_x = applied_x + STEP_X;
        else if (diff_x < -STEP_X)
            slewed_x = applied_x - STEP_X;
        else
            slewed_x = target_x;

        if (!bus.enable) begin
            applied_nxt = '0;
            dir_nxt     = 1'b0;
            sat_nxt     = 1'b0;
            dt_nxt      = '0;
            force_low   = 1'b1;
        end else if (boundary) begin
            applied_nxt = slewed_x[WIDTH-1:0];
            sat_nxt     = sat_smp;
            dir_nxt     = !slewed_x[WIDTH] && (slewed_x != '0);
            dt_nxt      = '0;
            if ((DEADTIME > 0) && (dir_nxt != dir_q)) begin
                dt_nxt    = DT_LOAD;
                force_low = 1'b1;
            end
        end else if (dt_cnt != '0) begin
            dt_nxt    = dt_cnt - WIDTH'(1);
            force_low = 1'b1;
        end

        mag = applied_nxt[WIDTH-1] ? $unsigned(-applied_nxt) : $unsigned(applied_nxt);
        if (CENTER != 0)
            hit = (cnt_nxt >= PER_W - mag);
        else
            hit = (cnt_nxt < mag);

        pwm_nxt  = hit && !force_low;
        sync_nxt = boundary;
    end

    assign bus.dir  = dir_q;
    assign bus.pwm  = pwm_q;
    assign bus.sync = sync_q;
    assign bus.sat  = sat_q;

endmodule

// File: tb/tb_vout_pwm_ramp.sv
// Directed bench for vout_pwm_ramp: five instances cover edge, center,
// ramp, dead-time and saturation configurations sharing one clock/reset.
module tb_vout_pwm_ramp;

    logic clk;
    logic reset;

    logic signed [31:0] dty_v [5];
    logic [4:0]         en_v;
    logic [4:0]         pwm_a, sync_a, dir_a, sat_a;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                 dut;
        bit                 set;
        logic signed [31:0] dty;
        int                 len;
        int                 highs;
        int                 first;
        logic               dir;
        logic               sat;
    } vec_t;

    vec_t tbl [22];

    vout_pwm_ramp_if #(.WIDTH(16)) if_e ();
    vout_pwm_ramp_if #(.WIDTH(16)) if_c ();
    vout_pwm_ramp_if #(.WIDTH(16)) if_r ();
    vout_pwm_ramp_if #(.WIDTH(16)) if_d ();
    vout_pwm_ramp_if #(.WIDTH(32)) if_s ();

    assign if_e.dty = dty_v[0][15:0];
    assign if_c.dty = dty_v[1][15:0];
    assign if_r.dty = dty_v[2][15:0];
    assign if_d.dty = dty_v[3][15:0];
    assign if_s.dty = dty_v[4];
    assign if_e.enable = en_v[0];
    assign if_c.enable = en_v[1];
    assign if_r.enable = en_v[2];
    assign if_d.enable = en_v[3];
    assign if_s.enable = en_v[4];

    assign pwm_a  = {if_s.pwm,  if_d.pwm,  if_r.pwm,  if_c.pwm,  if_e.pwm};
    assign sync_a = {if_s.sync, if_d.sync, if_r.sync, if_c.sync, if_e.sync};
    assign dir_a  = {if_s.dir,  if_d.dir,  if_r.dir,  if_c.dir,  if_e.dir};
    assign sat_a  = {if_s.sat,  if_d.sat,  if_r.sat,  if_c.sat,  if_e.sat};

    vout_pwm_ramp #(.WIDTH(16), .PERIOD(10))
        u_edge (.clk(clk), .reset(reset), .bus(if_e));
    vout_pwm_ramp #(.WIDTH(16), .PERIOD(8), .CENTER(1))
        u_ctr (.clk(clk), .reset(reset), .bus(if_c));
    vout_pwm_ramp #(.WIDTH(16), .PERIOD(100), .RAMP_STEP(2))
        u_ramp (.clk(clk), .reset(reset), .bus(if_r));
    vout_pwm_ramp #(.WIDTH(16), .PERIOD(10), .DEADTIME(4))
        u_dt (.clk(clk), .reset(reset), .bus(if_d));
    vout_pwm_ramp #(.WIDTH(32), .PERIOD(255))
        u_sat (.clk(clk), .reset(reset), .bus(if_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sync(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync_a[d] && n < 600);
        if (!sync_a[d]) begin
            total++;
            bad++;
            $display("FAIL sync_timeout dut%0d: got no sync within %0d clocks", d, n);
        end
    endtask

    task automatic measure(input int d, input int len, output int highs, output int first,
                           output int last, output int nsync, output logic dir0,
                           output logic sat0);
        highs = 0;
        first = -1;
        last  = -1;
        nsync = 0;
        dir0  = dir_a[d];
        sat0  = sat_a[d];
        for (int i = 0; i < len; i++) begin
            if (pwm_a[d]) begin
                if (first < 0) first = i;
                last = i;
                highs++;
            end
            if (sync_a[d]) nsync++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   highs, first, last, nsync, span;
        logic dir0, sat0;
        if (v.set) begin
            dty_v[v.dut] = v.dty;
            wait_sync(v.dut);
        end
        measure(v.dut, v.len, highs, first, last, nsync, dir0, sat0);
        span = (highs == 0) ? 0 : last - first + 1;
        chk($sformatf("v%0d_highs", idx), highs, v.highs);
        chk($sformatf("v%0d_first", idx), first, v.first);
        chk($sformatf("v%0d_span", idx), span, v.highs);
        chk($sformatf("v%0d_dir", idx), dir0, v.dir);
        chk($sformatf("v%0d_sat", idx), sat0, v.sat);
        chk($sformatf("v%0d_nsync", idx), nsync, 1);
    endtask

    initial begin
        int   highs, first, last, nsync, lows, n;
        logic dir0, sat0;

        // edge, PERIOD=10
        tbl[0]  = '{0, 1'b1,  32'sd3,  10,  3, 0, 1'b1, 1'b0};
        tbl[1]  = '{0, 1'b1,  32'sd0,  10,  0, -1, 1'b0, 1'b0};
        tbl[2]  = '{0, 1'b1,  32'sd10, 10, 10, 0, 1'b1, 1'b0};
        tbl[3]  = '{0, 1'b1, -32'sd4,  10,  4, 0, 1'b0, 1'b0};
        tbl[4]  = '{0, 1'b1,  32'sd12, 10, 10, 0, 1'b1, 1'b1};
        tbl[5]  = '{0, 1'b1, -32'sd10, 10, 10, 0, 1'b0, 1'b0};
        tbl[6]  = '{0, 1'b1, -32'sd11, 10, 10, 0, 1'b0, 1'b1};
        tbl[7]  = '{0, 1'b1,  32'sd9,  10,  9, 0, 1'b1, 1'b0};
        // center, PERIOD=8: high for counter 5,6,7 up and 7,6,5 down
        tbl[8]  = '{1, 1'b1, -32'sd3,  16,  6, 5, 1'b0, 1'b0};
        // ramp step 2, PERIOD=100
        tbl[9]  = '{2, 1'b1,  32'sd7, 100,  2, 0, 1'b1, 1'b0};
        tbl[10] = '{2, 1'b0,  32'sd7, 100,  4, 0, 1'b1, 1'b0};
        tbl[11] = '{2, 1'b0,  32'sd7, 100,  6, 0, 1'b1, 1'b0};
        tbl[12] = '{2, 1'b0,  32'sd7, 100,  7, 0, 1'b1, 1'b0};
        tbl[13] = '{2, 1'b1, -32'sd3, 100,  5, 0, 1'b1, 1'b0};
        tbl[14] = '{2, 1'b0, -32'sd3, 100,  3, 0, 1'b1, 1'b0};
        tbl[15] = '{2, 1'b0, -32'sd3, 100,  1, 0, 1'b1, 1'b0};
        tbl[16] = '{2, 1'b0, -32'sd3, 100,  1, 0, 1'b0, 1'b0};
        tbl[17] = '{2, 1'b0, -32'sd3, 100,  3, 0, 1'b0, 1'b0};
        // dead time 4, PERIOD=10: reversing period keeps only counter 4 high
        tbl[18] = '{3, 1'b1,  32'sd5,  10,  1, 4, 1'b1, 1'b0};
        tbl[19] = '{3, 1'b0,  32'sd5,  10,  5, 0, 1'b1, 1'b0};
        tbl[20] = '{3, 1'b1, -32'sd5,  10,  1, 4, 1'b0, 1'b0};
        tbl[21] = '{3, 1'b0, -32'sd5,  10,  5, 0, 1'b0, 1'b0};

        reset = 1'b1;
        en_v  = 5'b11111;
        for (int i = 0; i < 5; i++) dty_v[i] = 32'sd0;
        repeat (3) @(negedge clk);
        chk("reset_pwm",  pwm_a,  0);
        chk("reset_sync", sync_a, 0);
        chk("reset_dir",  dir_a,  0);
        chk("reset_sat",  sat_a,  0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) run_vec(tbl[i], i);

        // saturation and mid-period duty change, PERIOD=255
        run_vec('{4, 1'b1, 32'sd300, 255, 255, 0, 1'b1, 1'b1}, 30);
        repeat (5) @(negedge clk);
        dty_v[4] = 32'sd10;
        lows = 0;
        n    = 0;
        while (!sync_a[4] && n < 600) begin
            if (!pwm_a[4]) lows++;
            if (!sat_a[4]) lows++;
            @(negedge clk);
            n++;
        end
        chk("midchange_hold", lows, 0);
        chk("midchange_sync", sync_a[4], 1);
        run_vec('{4, 1'b0, 32'sd10, 255, 10, 0, 1'b1, 1'b0}, 31);
        run_vec('{4, 1'b1, 32'sh8000_0000, 255, 255, 0, 1'b0, 1'b1}, 32);

        // asynchronous reset while outputs are high
        run_vec('{0, 1'b1, 32'sd10, 10, 10, 0, 1'b1, 1'b0}, 33);
        chk("pre_rst_pwm",  pwm_a[0],  1);
        chk("pre_rst_sync", sync_a[0], 1);
        chk("pre_rst_sat",  sat_a[4],  1);
        reset = 1'b1;
        #1;
        chk("async_rst_pwm",  pwm_a,  0);
        chk("async_rst_sync", sync_a, 0);
        chk("async_rst_dir",  dir_a,  0);
        chk("async_rst_sat",  sat_a,  0);
        @(negedge clk);
        @(negedge clk);
        chk("in_rst_sync", sync_a, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_sync", sync_a, 5'b11111);
        chk("post_rst_pwm",  pwm_a[0], 1);
        @(negedge clk);
        chk("post_rst_sync2", sync_a[0], 0);

        // enable drop mid-period
        repeat (2) @(negedge clk);
        chk("pre_dis_pwm", pwm_a[0], 1);
        en_v[0] = 1'b0;
        @(negedge clk);
        chk("dis_pwm", pwm_a[0], 0);
        chk("dis_dir", dir_a[0], 0);
        measure(0, 20, highs, first, last, nsync, dir0, sat0);
        chk("dis_highs", highs, 0);
        chk("dis_nsync", nsync, 2);
        en_v[0] = 1'b1;
        run_vec('{0, 1'b1, 32'sd10, 10, 10, 0, 1'b1, 1'b0}, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vout_pwm_ramp.md
Name: vout_pwm_ramp

Overview:
- Parametrised successor to the single-channel sign/magnitude PWM output used for analogue-style joint and spindle voltage outputs.
- Adds:
  - configurable counter width and period;
  - edge- or center-aligned modulation;
  - duty updates only at period boundaries (glitch-free);
  - magnitude saturation;
  - per-period slew limiting;
  - dead time on direction reversal.
- Sits between the host-written signed duty register and the H-bridge / DAC-filter pins.

Parameters:
- WIDTH, 32, width of signed duty input; magnitude arithmetic at WIDTH bits.
- PERIOD, 255, PWM period in clocks (edge mode) or half-period (center mode); range 2..2^(WIDTH-1)-1.
- CENTER, 0, 0 = edge-aligned, 1 = center-aligned.
- RAMP_STEP, 0, maximum change of applied signed duty per period; 0 = no limiting.
- DEADTIME, 0, clocks of forced-low pwm at the start of the period in which dir changes; must be < PERIOD.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  0 = pwm held low, state cleared as reset except counter keeps running
- dty  in  WIDTH  signed requested duty; magnitude in clocks per PERIOD
- dir  out  1  1 when applied duty > 0, else 0
- pwm  out  1  modulated output
- sync  out  1  one-clock pulse on the first clock of each period
- sat  out  1  high while the sampled |dty| exceeds PERIOD

Behaviour:

Reset:
- counter = 0, applied duty = 0, dir = 0, pwm = 0, sync = 0, sat = 0, deadtime counter = 0.

Counter:
- Edge mode: counts 0..PERIOD-1 and wraps; period = PERIOD clocks.
- Center mode: counts up 0..PERIOD-1, then down PERIOD-1..0 (each endpoint held one clock per phase); period = 2*PERIOD clocks.

Boundary and sampling:
- The boundary is the clock on which the counter equals 0 at the start of the (up) phase.
- sync is registered high for exactly that clock.

Sampling at boundary:
- Target = dty, clamped to ±PERIOD.
- sat = 1 if |dty| > PERIOD, else 0.
- Note: -2^(WIDTH-1) must clamp to -PERIOD without overflow.

Slew:
- If RAMP_STEP = 0, applied = target.
- Otherwise applied moves toward target by min(RAMP_STEP, |target - applied|).
- The difference is computed at WIDTH+1 bits.

Direction:
- dir = 1 if applied > 0, else 0 (zero counts as 0).
- dir updates on the boundary clock.

Dead time:
- Triggered when dir changes value at a boundary and DEADTIME > 0.
- pwm is forced 0 for the first DEADTIME clocks of that period, including the boundary clock.

Modulation (m = |applied|, pwm registered from current counter):
- Edge mode: pwm = 1 while counter < m. Gives exactly m high clocks per period: m = 0 never high, m = PERIOD always high.
- Center mode: pwm = 1 while counter >= PERIOD - m in both phases. Gives 2*m high clocks, centered on the top of the triangle.
- dty changes mid-period have no effect until the next boundary.

Enable:
- enable = 0: pwm = 0, applied = 0, dir = 0, sat = 0 on the next clock; counter and sync continue.
- enable rising: the first sample is taken at the next boundary, with ramping from 0.

Reset mid-period:
- Asynchronous clear of all state.
- The first boundary is the first clock after reset deasserts.

Test Plan:
- Edge mode, PERIOD = 10, dty = 3 held → every period pwm high 3 consecutive clocks starting at sync, dir = 1, sat = 0; dty = 0 → pwm never high; dty = 10 → pwm constantly high.
- Center mode, PERIOD = 8, dty = -3 → 16-clock period; pwm high 6 clocks, centered on counter = 7; dir = 0.
- RAMP_STEP = 2, PERIOD = 100, dty stepped 0 → 7 → applied magnitude 2, 4, 6, 7 in successive periods; step 7 → -3 → applied 5, 3, 1, -1, -3 with dir falling at the period applying -1.
- DEADTIME = 4, dty +5 → -5 (no ramp) → at the reversing boundary dir toggles and pwm stays low for 4 clocks, then follows m = 5; the next period has no forced-low clocks.
- dty = 300 with PERIOD = 255, and dty = most-negative WIDTH value → applied clamps to +255 / -255, sat = 1; dty changed mid-period → no output change before the next sync.
- Assert reset mid-period with pwm high → pwm, dir, sync, sat drop to 0 asynchronously; after release sync pulses on the first clock; deassert enable mid-period → pwm low the next clock, sync still periodic.
